// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the RV32 pipeline hazard controller.
//   stage_entry_t : what the tracker remembers about one post-decode stage
//   FWD_SEL_RF    : forward-select value meaning "use register-file data"
//   STAGE_BUBBLE  : an empty (invalid) tracker entry
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Width of the rd field held in each tracker entry; this must equal the
  // REG_ADDR_W parameter used by the controller (5 for RV32).
  localparam int TRACK_RD_W = 5;

  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [TRACK_RD_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } stage_entry_t;

  localparam stage_entry_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/pipe_fwd_mux.sv
// ---------------------------------------------------------------------------
// pipe_fwd_mux
// Forwarding selector for one decode operand. Scans the tracked stages for
// the youngest instruction that will write the operand's register and picks
// that stage's result, otherwise the register-file value.
// Ports:
//   rs_req_i       : operand is really read by a valid decode instruction
//   rs_i           : operand register address
//   rf_data_i      : register-file read data for the operand
//   stage_i        : tracker entries, index 0 = EX (youngest)
//   stage_result_i : per-stage result values, slice k = stage k
//   sel_o          : 0 = register file, k+1 = stage k
//   data_o         : forwarded operand value
//   load_hazard_o  : youngest match is a load whose data is not ready yet
// ---------------------------------------------------------------------------
module pipe_fwd_mux
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STAGE = 1,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                         rs_req_i,
  input  logic [REG_ADDR_W-1:0]        rs_i,
  input  logic [XLEN-1:0]              rf_data_i,
  input  stage_entry_t [NUM_STAGES-1:0] stage_i,
  input  logic [NUM_STAGES*XLEN-1:0]   stage_result_i,
  output logic [FWD_W-1:0]             sel_o,
  output logic [XLEN-1:0]              data_o,
  output logic                         load_hazard_o
);

  // Walk from the oldest stage down to EX so the last hit written is the
  // youngest one, giving lowest-index priority. x0 never matches.
  always_comb begin
    sel_o         = FWD_W'(FWD_SEL_RF);
    data_o        = rf_data_i;
    load_hazard_o = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (rs_req_i && (rs_i != '0) && stage_i[k].valid &&
          stage_i[k].reg_write && (stage_i[k].rd == rs_i)) begin
        sel_o         = FWD_W'(k + 1);
        data_o        = stage_result_i[k*XLEN +: XLEN];
        load_hazard_o = stage_i[k].is_load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, forwarding and bubble-tracking controller beside the decode stage.
// Mirrors rd/control of every instruction in EX..WB, stalls decode on a
// load-use hazard, flushes IF/ID on a taken branch and forwards operands.
// Ports:
//   clk_i, reset_i            : clock, async active-high reset
//   id_*                      : decode-stage instruction info and RF data
//   ex_branch_taken_i         : branch/jump resolved taken in EX
//   stage_result_i            : per-stage result values, slice k = stage k
//   stall_id_o                : hold PC and IF/ID, bubble into EX
//   flush_if_o, flush_id_o    : squash IF and ID instructions
//   fwd_rs1_sel_o/rs2_sel_o   : 0 = register file, k+1 = stage k
//   rs1_data_o, rs2_data_o    : forwarded operand data
//   stage_valid_o             : tracker valid bits
//   stall_cnt_o, flush_cnt_o  : saturating statistics counters
// Optional: define PIPE_HAZARD_STATS_EN to build the statistics counters;
// otherwise both counter ports are tied to 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STAGE = 1,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       id_valid_i,
  input  logic [REG_ADDR_W-1:0]      id_rs1_i,
  input  logic [REG_ADDR_W-1:0]      id_rs2_i,
  input  logic                       id_rs1_used_i,
  input  logic                       id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0]      id_rd_i,
  input  logic                       id_reg_write_i,
  input  logic                       id_is_load_i,
  input  logic [XLEN-1:0]            id_rs1_data_i,
  input  logic [XLEN-1:0]            id_rs2_data_i,
  input  logic                       ex_branch_taken_i,
  input  logic [NUM_STAGES*XLEN-1:0] stage_result_i,
  output logic                       stall_id_o,
  output logic                       flush_if_o,
  output logic                       flush_id_o,
  output logic [FWD_W-1:0]           fwd_rs1_sel_o,
  output logic [FWD_W-1:0]           fwd_rs2_sel_o,
  output logic [XLEN-1:0]            rs1_data_o,
  output logic [XLEN-1:0]            rs2_data_o,
  output logic [NUM_STAGES-1:0]      stage_valid_o,
  output logic [15:0]                stall_cnt_o,
  output logic [15:0]                flush_cnt_o
);

  stage_entry_t [NUM_STAGES-1:0] stage_q;
  stage_entry_t [NUM_STAGES-1:0] stage_d;
  logic rs1_load_hazard;
  logic rs2_load_hazard;

  pipe_fwd_mux #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W),
    .LOAD_STAGE(LOAD_STAGE), .FWD_W(FWD_W)
  ) u_fwd_rs1 (
    .rs_req_i      (id_valid_i & id_rs1_used_i),
    .rs_i          (id_rs1_i),
    .rf_data_i     (id_rs1_data_i),
    .stage_i       (stage_q),
    .stage_result_i(stage_result_i),
    .sel_o         (fwd_rs1_sel_o),
    .data_o        (rs1_data_o),
    .load_hazard_o (rs1_load_hazard)
  );

  pipe_fwd_mux #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W),
    .LOAD_STAGE(LOAD_STAGE), .FWD_W(FWD_W)
  ) u_fwd_rs2 (
    .rs_req_i      (id_valid_i & id_rs2_used_i),
    .rs_i          (id_rs2_i),
    .rf_data_i     (id_rs2_data_i),
    .stage_i       (stage_q),
    .stage_result_i(stage_result_i),
    .sel_o         (fwd_rs2_sel_o),
    .data_o        (rs2_data_o),
    .load_hazard_o (rs2_load_hazard)
  );

  // A taken branch squashes the decode instruction anyway, so it overrides
  // any load-use stall raised by that instruction.
  assign stall_id_o = (rs1_load_hazard | rs2_load_hazard) & ~ex_branch_taken_i;
  assign flush_if_o = ex_branch_taken_i;
  assign flush_id_o = ex_branch_taken_i;

  // Tracker shifts every cycle; EX takes the decode instruction only when it
  // really leaves decode, otherwise a bubble.
  always_comb begin
    stage_d = stage_q;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      stage_d[k] = stage_q[k-1];
    end
    if (id_valid_i && !stall_id_o && !flush_id_o) begin
      stage_d[0] = '{valid: 1'b1, rd: id_rd_i, reg_write: id_reg_write_i,
                     is_load: id_is_load_i};
    end else begin
      stage_d[0] = STAGE_BUBBLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= STAGE_BUBBLE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    stage_valid_o = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_valid_o[k] = stage_q[k].valid;
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: they stick at 0xFFFF rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_id_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_id_o && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. A reference model keeps the
// in-flight instructions as a list ordered by age and derives stall, flush,
// forwarding and counter values from the hazard rules directly.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int NUM_STAGES = 3;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LOAD_STAGE = 1;
  localparam int FWD_W      = $clog2(NUM_STAGES + 1);

  logic                       clk;
  logic                       reset_i;
  logic                       id_valid_i;
  logic [REG_ADDR_W-1:0]      id_rs1_i;
  logic [REG_ADDR_W-1:0]      id_rs2_i;
  logic                       id_rs1_used_i;
  logic                       id_rs2_used_i;
  logic [REG_ADDR_W-1:0]      id_rd_i;
  logic                       id_reg_write_i;
  logic                       id_is_load_i;
  logic [XLEN-1:0]            id_rs1_data_i;
  logic [XLEN-1:0]            id_rs2_data_i;
  logic                       ex_branch_taken_i;
  logic [NUM_STAGES*XLEN-1:0] stage_result_i;
  logic                       stall_id_o;
  logic                       flush_if_o;
  logic                       flush_id_o;
  logic [FWD_W-1:0]           fwd_rs1_sel_o;
  logic [FWD_W-1:0]           fwd_rs2_sel_o;
  logic [XLEN-1:0]            rs1_data_o;
  logic [XLEN-1:0]            rs2_data_o;
  logic [NUM_STAGES-1:0]      stage_valid_o;
  logic [15:0]                stall_cnt_o;
  logic [15:0]                flush_cnt_o;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W),
    .LOAD_STAGE(LOAD_STAGE), .FWD_W(FWD_W)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .id_rd_i          (id_rd_i),
    .id_reg_write_i   (id_reg_write_i),
    .id_is_load_i     (id_is_load_i),
    .id_rs1_data_i    (id_rs1_data_i),
    .id_rs2_data_i    (id_rs2_data_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .stage_result_i   (stage_result_i),
    .stall_id_o       (stall_id_o),
    .flush_if_o       (flush_if_o),
    .flush_id_o       (flush_id_o),
    .fwd_rs1_sel_o    (fwd_rs1_sel_o),
    .fwd_rs2_sel_o    (fwd_rs2_sel_o),
    .rs1_data_o       (rs1_data_o),
    .rs2_data_o       (rs2_data_o),
    .stage_valid_o    (stage_valid_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight instruction as seen by the model; array index = age in
  // cycles since it left decode (0 = in EX).
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  instr_t pipeModel[NUM_STAGES];
  bit     expStall;
  bit     expFlush;
  int     expStallCnt;
  int     expFlushCnt;
  int     checkCount;
  int     errorCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Age of the most recent in-flight writer of rs, or -1 when the operand
  // must come from the register file.
  function automatic int youngestWriter(bit idv, int rs, bit used);
    if (!idv || !used || rs == 0) return -1;
    for (int age = 0; age < NUM_STAGES; age++) begin
      if (pipeModel[age].v && pipeModel[age].wr && pipeModel[age].rd == rs) return age;
    end
    return -1;
  endfunction

  task automatic clearModel();
    for (int a = 0; a < NUM_STAGES; a++) pipeModel[a] = '{0, 0, 0, 0};
    expStallCnt = 0;
    expFlushCnt = 0;
  endtask

  // Drive one decode instruction at the falling edge, then compare every
  // output against the model just after the inputs settle.
  task automatic applyStimulus(input bit v, input logic [4:0] rs1, input bit u1,
                               input logic [4:0] rs2, input bit u2,
                               input logic [4:0] rd, input bit wr, input bit ld,
                               input bit br);
    int h1, h2;
    bit lu1, lu2;
    logic [NUM_STAGES-1:0] expValid;
    logic [XLEN-1:0] expD1, expD2;
    @(negedge clk);
    id_valid_i = v; id_rs1_i = rs1; id_rs1_used_i = u1; id_rs2_i = rs2;
    id_rs2_used_i = u2; id_rd_i = rd; id_reg_write_i = wr; id_is_load_i = ld;
    ex_branch_taken_i = br;
    id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
    for (int k = 0; k < NUM_STAGES; k++) stage_result_i[k*XLEN +: XLEN] = $urandom;
    #1;
    h1  = youngestWriter(v, int'(rs1), u1);
    h2  = youngestWriter(v, int'(rs2), u2);
    lu1 = (h1 >= 0) && pipeModel[h1 < 0 ? 0 : h1].ld && (h1 < LOAD_STAGE);
    lu2 = (h2 >= 0) && pipeModel[h2 < 0 ? 0 : h2].ld && (h2 < LOAD_STAGE);
    expFlush = br;
    expStall = (lu1 || lu2) && !br;
    for (int k = 0; k < NUM_STAGES; k++) expValid[k] = pipeModel[k].v;
    checkOutput("stall", 32'(stall_id_o), 32'(expStall));
    checkOutput("flushIf", 32'(flush_if_o), 32'(expFlush));
    checkOutput("flushId", 32'(flush_id_o), 32'(expFlush));
    checkOutput("stageValid", 32'(stage_valid_o), 32'(expValid));
    checkOutput("stallCnt", 32'(stall_cnt_o), 32'(expStallCnt));
    checkOutput("flushCnt", 32'(flush_cnt_o), 32'(expFlushCnt));
    if (!expStall) begin
      expD1 = (h1 >= 0) ? stage_result_i[h1*XLEN +: XLEN] : id_rs1_data_i;
      expD2 = (h2 >= 0) ? stage_result_i[h2*XLEN +: XLEN] : id_rs2_data_i;
      checkOutput("rs1Sel", 32'(fwd_rs1_sel_o), 32'(h1 + 1));
      checkOutput("rs2Sel", 32'(fwd_rs2_sel_o), 32'(h2 + 1));
      checkOutput("rs1Data", rs1_data_o, expD1);
      checkOutput("rs2Data", rs2_data_o, expD2);
    end
  endtask

  // Rising edge: everything ages one stage; the decode instruction joins
  // only if it actually left decode this cycle.
  task automatic advanceClock();
    @(posedge clk);
    if (reset_i) begin
      clearModel();
    end else begin
`ifdef PIPE_HAZARD_STATS_EN
      if (expStall && expStallCnt < 16'hFFFF) expStallCnt++;
      if (expFlush && expFlushCnt < 16'hFFFF) expFlushCnt++;
`endif
      for (int a = NUM_STAGES - 1; a >= 1; a--) pipeModel[a] = pipeModel[a-1];
      if (id_valid_i && !expStall && !expFlush)
        pipeModel[0] = '{1, int'(id_rd_i), id_reg_write_i, id_is_load_i};
      else
        pipeModel[0] = '{0, 0, 0, 0};
    end
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_STAGES; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      advanceClock();
    end
  endtask

  // Main sequence: reset, directed hazard scenarios, random traffic, then a
  // reset in the middle of a full pipeline.
  initial begin
    bit hv, hu1, hu2, hwr, hld, hbr;
    logic [4:0] hrs1, hrs2, hrd;
    checkCount = 0;
    errorCount = 0;
    clearModel();
    expStall = 0; expFlush = 0;
    reset_i = 1'b1;
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
    id_rd_i = 0; id_reg_write_i = 0; id_is_load_i = 0; ex_branch_taken_i = 0;
    id_rs1_data_i = 0; id_rs2_data_i = 0; stage_result_i = '0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstValid", 32'(stage_valid_o), 32'd0);
    checkOutput("rstSel1", 32'(fwd_rs1_sel_o), 32'd0);
    advanceClock();
    #2 reset_i = 1'b0;

    // ADD x5 followed by ADD x6,x5,x0: EX forward on rs1 only.
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
    advanceClock();
    applyStimulus(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0);
    checkOutput("addFwdSel1", 32'(fwd_rs1_sel_o), 32'd1);
    checkOutput("addFwdData1", rs1_data_o, stage_result_i[0 +: XLEN]);
    checkOutput("addFwdSel2", 32'(fwd_rs2_sel_o), 32'd0);
    advanceClock();
    drain();

    // LW x7 then ADD x8,x7,x7: one stall, bubble, then forward from MEM.
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
    advanceClock();
    applyStimulus(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
    checkOutput("luStall", 32'(stall_id_o), 32'd1);
    advanceClock();
    applyStimulus(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0);
    checkOutput("luStallEnd", 32'(stall_id_o), 32'd0);
    checkOutput("luBubble", 32'(stage_valid_o[0]), 32'd0);
    checkOutput("luSel1", 32'(fwd_rs1_sel_o), 32'd2);
    checkOutput("luSel2", 32'(fwd_rs2_sel_o), 32'd2);
    checkOutput("luData2", rs2_data_o, stage_result_i[XLEN +: XLEN]);
    advanceClock();
    drain();

    // x5 in both MEM and EX: EX wins. Then x0 is never forwarded.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    advanceClock();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    advanceClock();
    applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 1, 0, 0);
    checkOutput("prioSel1", 32'(fwd_rs1_sel_o), 32'd1);
    advanceClock();
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    checkOutput("x0Sel1", 32'(fwd_rs1_sel_o), 32'd0);
    advanceClock();
    drain();

    // Load-use hazard together with a taken branch: flush wins.
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
    advanceClock();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 1);
    checkOutput("brFlush", 32'(flush_id_o), 32'd1);
    checkOutput("brNoStall", 32'(stall_id_o), 32'd0);
    advanceClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("brBubble", 32'(stage_valid_o[0]), 32'd0);
    advanceClock();

    // Random traffic over a small register window to provoke many hits; a
    // stalled decode instruction is held, as the real pipeline would.
    hv = 0; hrs1 = 0; hu1 = 0; hrs2 = 0; hu2 = 0; hrd = 0; hwr = 0; hld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!expStall) begin
        hv   = ($urandom_range(0, 7) != 0);
        hrs1 = 5'($urandom_range(0, 7));
        hu1  = 1'($urandom_range(0, 1));
        hrs2 = 5'($urandom_range(0, 7));
        hu2  = 1'($urandom_range(0, 1));
        hrd  = 5'($urandom_range(0, 7));
        hwr  = ($urandom_range(0, 3) != 0);
        hld  = ($urandom_range(0, 2) == 0);
      end
      hbr = ($urandom_range(0, 9) == 0);
      applyStimulus(hv, hrs1, hu1, hrs2, hu2, hrd, hwr, hld, hbr);
      advanceClock();
    end
    drain();

    // Fill the pipeline, then assert reset between edges.
    for (int i = 0; i < NUM_STAGES; i++) begin
      applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'(11 + i), 1, 0, 0);
      advanceClock();
    end
    applyStimulus(1, 5'd11, 1, 5'd12, 1, 5'd20, 1, 0, 0);
    checkOutput("preRstValid", 32'(stage_valid_o), 32'h7);
    reset_i = 1'b1;
    #1;
    clearModel();
    checkOutput("midRstValid", 32'(stage_valid_o), 32'd0);
    checkOutput("midRstStall", 32'(stall_id_o), 32'd0);
    checkOutput("midRstFlush", 32'(flush_id_o), 32'd0);
    checkOutput("midRstSel1", 32'(fwd_rs1_sel_o), 32'd0);
    checkOutput("midRstSel2", 32'(fwd_rs2_sel_o), 32'd0);
    checkOutput("midRstStallCnt", 32'(stall_cnt_o), 32'd0);
    checkOutput("midRstFlushCnt", 32'(flush_cnt_o), 32'd0);
    advanceClock();
    #2 reset_i = 1'b0;
    applyStimulus(1, 5'd12, 1, 5'd13, 1, 5'd21, 1, 0, 0);
    checkOutput("postRstSel1", 32'(fwd_rs1_sel_o), 32'd0);
    advanceClock();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and bubble-tracking controller for the in-order RV32 pipeline.
- Sits beside the decode stage and mirrors the destination and control info of every instruction in the stages after decode (EX..WB).
- Generates decode stall, fetch/decode flush and per-operand forwarding selects, and drives the forwarded operand data.
- Supports any number of post-decode stages and any load-data-ready stage; the earlier fixed-depth pipeline had no hazard handling at all.

Parameters:
- NUM_STAGES, 3, tracked stages after decode; index 0 = EX, NUM_STAGES-1 = WB.
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- LOAD_STAGE, 1, first stage index whose stage_result_i holds valid load data (1 = MEM); range 0..NUM_STAGES-1.
- FWD_W, $clog2(NUM_STAGES+1), derived width of the forward select.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  decode holds a real instruction.
- id_rs1_i / id_rs2_i  in  REG_ADDR_W  source registers.
- id_rs1_used_i / id_rs2_used_i  in  1  source actually read.
- id_rd_i  in  REG_ADDR_W  destination register.
- id_reg_write_i  in  1  instruction writes rd.
- id_is_load_i  in  1  instruction is a load.
- id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data.
- ex_branch_taken_i  in  1  branch/jump resolved taken in EX.
- stage_result_i  in  NUM_STAGES*XLEN  per-stage value to be written (slice k = stage k).
- stall_id_o  out  1  hold PC and the IF/ID register; insert a bubble into EX.
- flush_if_o / flush_id_o  out  1  squash the IF and ID instructions.
- fwd_rs1_sel_o / fwd_rs2_sel_o  out  FWD_W  0 = register file, k+1 = stage k.
- rs1_data_o / rs2_data_o  out  XLEN  forwarded operand data.
- stage_valid_o  out  NUM_STAGES  tracker valid bits.
- stall_cnt_o / flush_cnt_o  out  16  statistics counters.

Behaviour:
- Tracker: one entry per stage holding {valid, rd, reg_write, is_load}.
  - Every cycle, stage k <= stage k-1 for k >= 1.
  - Stage 0 <= ID entry if id_valid_i & ~stall_id_o & ~flush_id_o; otherwise stage 0 <= bubble (valid=0).
- Reset (asynchronous): all entries invalid; all outputs 0 (selects 0, data = register-file data, counters 0).
- A match on stage k requires all of:
  - valid[k] & reg_write[k];
  - rd[k] != 0;
  - rd[k] == rsN;
  - id_valid_i and id_rsN_used_i.
- Forwarding:
  - Combinational, zero latency.
  - Youngest match (lowest k) wins; select = k+1, data = stage_result_i slice k.
  - No match gives select 0 and register-file data.
  - x0 is never forwarded.
- Load-use hazard: the youngest match is a load with k < LOAD_STAGE gives stall_id_o=1.
  - Forward selects are don't-care while stalled.
  - The stall repeats each cycle until the load reaches LOAD_STAGE.
  - Default config: exactly 1 stall cycle.
- Branch: ex_branch_taken_i=1 gives flush_if_o=flush_id_o=1 in the same cycle.
  - Stage 0 receives a bubble next cycle.
  - The EX instruction itself continues.
- Flush has priority over stall: stall_id_o = hazard & ~ex_branch_taken_i.
- Writeback-stage matches forward as normal, so no register-file write-through is required.
- Reset asserted mid-stream clears the tracker immediately; after release the first ID instruction enters with no forwarding.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- Defined: stall_cnt_o increments on each cycle with stall_id_o=1, and flush_cnt_o on each cycle with flush_id_o=1. Both saturate at 0xFFFF and are cleared by reset.
- Undefined: the counters are not built and both ports are constant 0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - stage_entry_t struct {valid, rd, reg_write, is_load};
  - FWD_SEL_RF = 0 constant;
  - a bubble constant.
- Sub-module pipe_fwd_mux: per-operand match/priority/select/data mux, instantiated twice (rs1, rs2).

Test Plan:
- Reset asserted mid-stream with 3 valid entries -> stage_valid_o = 000 immediately; stall, flush and selects 0.
- ADD x5 then ADD x6,x5,x0; stage_result_i[0]=0x00001234 -> fwd_rs1_sel_o=1, rs1_data_o=0x00001234, fwd_rs2_sel_o=0, no stall.
- LW x7 then ADD x8,x7,x7 -> stall_id_o=1 for 1 cycle, stage_valid_o[0]=0 next cycle, then both selects = 2, data = stage_result_i[1].
- x5 valid in both EX and MEM; ID reads x5 -> select 1 (EX wins); a separate instruction with rd=x0 and rs1=x0 -> select 0.
- Load-use hazard and ex_branch_taken_i=1 in the same cycle -> flush_if_o=flush_id_o=1, stall_id_o=0, bubble enters stage 0.
- With PIPE_HAZARD_STATS_EN: 3 stalls plus 2 flushes -> stall_cnt_o=3, flush_cnt_o=2; without the macro -> both read 0.
